// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller (32 lines x 4 words).
// Read hits are zero-latency. A read miss refills 4 words; a store always goes through to memory.
module dcache_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [9:0] Addr,
  input  logic       MemReady,
  output logic       Stall,
  output logic       CacheWE,
  output logic       CacheFill,
  output logic [4:0] CacheIdx,
  output logic [1:0] CacheOff,
  output logic       MemRdReq,
  output logic       MemWrReq,
  output logic [9:0] MemAddr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  tag_q [32];
  logic [31:0] valid_q;

  logic [2:0]  addr_tag;
  logic [4:0]  addr_idx;
  logic [1:0]  addr_off;
  logic        hit;
  logic        miss_start;
  logic        refill_done;

  assign addr_tag = Addr[9:7];
  assign addr_idx = Addr[6:2];
  assign addr_off = Addr[1:0];
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Stores take priority, so a combined request is handled as a store only.
  assign miss_start  = (state_q == IDLE) && !MemWrite && MemRead && !hit;
  assign refill_done = (state_q == REFILL) && MemReady && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The line is invalidated on refill entry so an abandoned refill never leaves stale data marked valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < 32; i++) begin
        tag_q[i] <= 3'd0;
      end
    end else begin
      if (miss_start) begin
        valid_q[addr_idx] <= 1'b0;
      end
      if (refill_done) begin
        tag_q[addr_idx]   <= addr_tag;
        valid_q[addr_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          state_d = WRITE;
        end else if (MemRead && !hit) begin
          state_d = REFILL;
          cnt_d   = 2'd0;
        end
      end
      REFILL: begin
        if (MemReady) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (MemReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    Stall     = 1'b0;
    CacheWE   = 1'b0;
    CacheFill = 1'b0;
    CacheIdx  = addr_idx;
    CacheOff  = addr_off;
    MemRdReq  = 1'b0;
    MemWrReq  = 1'b0;
    MemAddr   = 10'd0;
    case (state_q)
      IDLE: begin
        Stall = MemWrite || (MemRead && !hit);
      end
      REFILL: begin
        Stall    = 1'b1;
        MemRdReq = 1'b1;
        MemAddr  = {Addr[9:2], cnt_q};
        CacheOff = cnt_q;
        if (MemReady) begin
          CacheWE   = 1'b1;
          CacheFill = 1'b1;
        end
      end
      WRITE: begin
        Stall    = !MemReady;
        MemWrReq = 1'b1;
        MemAddr  = Addr;
        // Only a store that hits updates the cached copy; misses go to memory alone.
        if (MemReady) begin
          CacheWE = hit;
        end
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: per-cycle vector table plus hand-written reset sequences.
module tb_dcache_ctrl;

  logic       clk;
  logic       rst_n;
  logic       MemRead;
  logic       MemWrite;
  logic [9:0] Addr;
  logic       MemReady;
  logic       Stall;
  logic       CacheWE;
  logic       CacheFill;
  logic [4:0] CacheIdx;
  logic [1:0] CacheOff;
  logic       MemRdReq;
  logic       MemWrReq;
  logic [9:0] MemAddr;

  int n_chk;
  int n_fail;

  dcache_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .MemReady (MemReady),
    .Stall    (Stall),
    .CacheWE  (CacheWE),
    .CacheFill(CacheFill),
    .CacheIdx (CacheIdx),
    .CacheOff (CacheOff),
    .MemRdReq (MemRdReq),
    .MemWrReq (MemWrReq),
    .MemAddr  (MemAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [9:0] addr;
    logic       rdy;
    logic       stall;
    logic       we;
    logic       fill;
    logic [1:0] off;
    logic       rdq;
    logic       wrq;
    logic [9:0] maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [9:0] addr, input logic rdy,
                              input logic stall, input logic we, input logic fill, input logic [1:0] off,
                              input logic rdq, input logic wrq, input logic [9:0] maddr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.rdy = rdy;
    v.stall = stall; v.we = we; v.fill = fill; v.off = off;
    v.rdq = rdq; v.wrq = wrq; v.maddr = maddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t v);
    logic [9:0] a;
    a = v.addr;
    chk({nm, " Stall"},     {9'd0, Stall},     {9'd0, v.stall});
    chk({nm, " CacheWE"},   {9'd0, CacheWE},   {9'd0, v.we});
    chk({nm, " CacheFill"}, {9'd0, CacheFill}, {9'd0, v.fill});
    chk({nm, " CacheOff"},  {8'd0, CacheOff},  {8'd0, v.off});
    chk({nm, " CacheIdx"},  {5'd0, CacheIdx},  {5'd0, a[6:2]});
    chk({nm, " MemRdReq"},  {9'd0, MemRdReq},  {9'd0, v.rdq});
    chk({nm, " MemWrReq"},  {9'd0, MemWrReq},  {9'd0, v.wrq});
    chk({nm, " MemAddr"},   MemAddr,           v.maddr);
  endtask

  task automatic apply(input vec_t v);
    MemRead  = v.rd;
    MemWrite = v.wr;
    Addr     = v.addr;
    MemReady = v.rdy;
  endtask

  // Full refill of the line holding a, MemReady high every cycle, then a hit check.
  task automatic refill_all(input string nm, input logic [9:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    @(negedge clk);
    apply(mk(1, 0, a, 0, 1, 0, 0, a[1:0], 0, 0, 10'd0));
    #1 chk_vec({nm, " miss"}, mk(1, 0, a, 0, 1, 0, 0, a[1:0], 0, 0, 10'd0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      apply(mk(1, 0, a, 1, 1, 1, 1, 2'(k), 1, 0, base + 10'(k)));
      #1 chk_vec($sformatf("%s fill%0d", nm, k), mk(1, 0, a, 1, 1, 1, 1, 2'(k), 1, 0, base + 10'(k)));
    end
    @(negedge clk);
    apply(mk(1, 0, a, 0, 0, 0, 0, a[1:0], 0, 0, 10'd0));
    #1 chk_vec({nm, " hit"}, mk(1, 0, a, 0, 0, 0, 0, a[1:0], 0, 0, 10'd0));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 10'd0;
    MemReady = 1'b0;

    //            rd wr addr    rdy stall we fill off rdq wrq maddr
    vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 2'd0, 0, 0, 10'h000));
    // read miss 0x085, MemReady every second cycle
    vecs.push_back(mk(1, 0, 10'h085, 0, 1, 0, 0, 2'd1, 0, 0, 10'h000));
    vecs.push_back(mk(1, 0, 10'h085, 1, 1, 1, 1, 2'd0, 1, 0, 10'h084));
    vecs.push_back(mk(1, 0, 10'h085, 0, 1, 0, 0, 2'd1, 1, 0, 10'h085));
    vecs.push_back(mk(1, 0, 10'h085, 1, 1, 1, 1, 2'd1, 1, 0, 10'h085));
    vecs.push_back(mk(1, 0, 10'h085, 0, 1, 0, 0, 2'd2, 1, 0, 10'h086));
    vecs.push_back(mk(1, 0, 10'h085, 1, 1, 1, 1, 2'd2, 1, 0, 10'h086));
    vecs.push_back(mk(1, 0, 10'h085, 0, 1, 0, 0, 2'd3, 1, 0, 10'h087));
    vecs.push_back(mk(1, 0, 10'h085, 1, 1, 1, 1, 2'd3, 1, 0, 10'h087));
    vecs.push_back(mk(1, 0, 10'h085, 0, 0, 0, 0, 2'd1, 0, 0, 10'h000));
    // store hit 0x086, MemReady three cycles into WRITE
    vecs.push_back(mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 0, 10'h000));
    vecs.push_back(mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 1, 10'h086));
    vecs.push_back(mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 1, 10'h086));
    vecs.push_back(mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 1, 10'h086));
    vecs.push_back(mk(0, 1, 10'h086, 1, 0, 1, 0, 2'd2, 0, 1, 10'h086));
    vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 2'd0, 0, 0, 10'h000));
    // store miss 0x286 (tag mismatch on line 1), then 0x085 must still hit
    vecs.push_back(mk(0, 1, 10'h286, 0, 1, 0, 0, 2'd2, 0, 0, 10'h000));
    vecs.push_back(mk(0, 1, 10'h286, 1, 0, 0, 0, 2'd2, 0, 1, 10'h286));
    vecs.push_back(mk(1, 0, 10'h085, 0, 0, 0, 0, 2'd1, 0, 0, 10'h000));
    // read and write together: store path only
    vecs.push_back(mk(1, 1, 10'h010, 0, 1, 0, 0, 2'd0, 0, 0, 10'h000));
    vecs.push_back(mk(1, 1, 10'h010, 1, 0, 0, 0, 2'd0, 0, 1, 10'h010));
    // stray MemReady in IDLE is ignored
    vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 0, 2'd0, 0, 0, 10'h000));
    vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 2'd0, 0, 0, 10'h000));

    #1 chk_vec("in_reset", mk(0, 0, 10'h000, 0, 0, 0, 0, 2'd0, 0, 0, 10'h000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk_vec($sformatf("row%0d", i), vecs[i]);
    end

    // reset in the middle of a refill of 0x3FF
    @(negedge clk);
    apply(mk(1, 0, 10'h3FF, 0, 1, 0, 0, 2'd3, 0, 0, 10'h000));
    #1 chk("rst_refill miss Stall", {9'd0, Stall}, 10'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      MemReady = 1'b1;
      #1 chk($sformatf("rst_refill fill%0d MemAddr", k), MemAddr, 10'h3FC + 10'(k));
    end
    @(negedge clk);
    MemReady = 1'b0;
    #1 chk("rst_refill pre MemAddr", MemAddr, 10'h3FE);
    rst_n   = 1'b0;
    MemRead = 1'b0;
    #1 chk_vec("rst_refill in_reset", mk(0, 0, 10'h3FF, 0, 0, 0, 0, 2'd3, 0, 0, 10'h000));
    @(negedge clk);
    rst_n = 1'b1;
    refill_all("rerd_3FF", 10'h3FF);
    // reset wiped line 1 as well
    refill_all("rerd_085", 10'h085);

    // reset in the middle of a store hit
    @(negedge clk);
    apply(mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 0, 10'h000));
    #1 chk_vec("rst_write idle", mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 0, 10'h000));
    @(negedge clk);
    #1 chk_vec("rst_write wait", mk(0, 1, 10'h086, 0, 1, 0, 0, 2'd2, 0, 1, 10'h086));
    rst_n    = 1'b0;
    MemWrite = 1'b0;
    MemReady = 1'b1;
    #1 chk_vec("rst_write in_reset", mk(0, 0, 10'h086, 1, 0, 0, 0, 2'd2, 0, 0, 10'h000));
    @(negedge clk);
    rst_n    = 1'b1;
    MemReady = 1'b0;
    #1 chk_vec("rst_write after", mk(0, 0, 10'h086, 0, 0, 0, 0, 2'd2, 0, 0, 10'h000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
